// File: rtl/rf_2w2r_sb.sv
// Two-write, two-read register file with a per-entry busy scoreboard,
// optional zero register, write-to-read bypass and a sequential clear engine.
module rf_2w2r_sb #(
    parameter int DATAWIDTH = 64,
    parameter int ADDRWIDTH = 3,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] raddr1,
    input  logic [ADDRWIDTH-1:0] raddr2,
    output logic [DATAWIDTH-1:0] rdata1,
    output logic [DATAWIDTH-1:0] rdata2,
    output logic                 rbusy1,
    output logic                 rbusy2,
    input  logic                 wen0,
    input  logic [ADDRWIDTH-1:0] waddr0,
    input  logic [DATAWIDTH-1:0] wdata0,
    input  logic                 wen1,
    input  logic [ADDRWIDTH-1:0] waddr1,
    input  logic [DATAWIDTH-1:0] wdata1,
    input  logic                 set_busy,
    input  logic [ADDRWIDTH-1:0] busy_addr,
    input  logic                 clr_all,
    output logic                 init_busy,
    output logic                 wr_conflict
);

    localparam int RFDEPTH = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(RFDEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] mem_q [RFDEPTH];
    logic [DATAWIDTH-1:0] mem_d [RFDEPTH];
    logic [RFDEPTH-1:0]   busy_q, busy_d;
    logic                 wr_conflict_q, wr_conflict_d;
    logic                 clearing;
    logic                 we0, we1, sb_en;

    function automatic logic is_zero_reg(input logic [ADDRWIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Read mux: zero register first, then bypass (port 1 wins), then storage.
    function automatic logic [DATAWIDTH-1:0] read_sel(
        input logic [ADDRWIDTH-1:0] ra,
        input logic [DATAWIDTH-1:0] stored,
        input logic                 w0,
        input logic [ADDRWIDTH-1:0] a0,
        input logic [DATAWIDTH-1:0] d0,
        input logic                 w1,
        input logic [ADDRWIDTH-1:0] a1,
        input logic [DATAWIDTH-1:0] d1
    );
        if (is_zero_reg(ra))
            return '0;
        if ((BYPASS != 0) && w1 && (a1 == ra))
            return d1;
        if ((BYPASS != 0) && w0 && (a0 == ra))
            return d0;
        return stored;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_all) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clearing  = (state_q == CLEAR);
        init_busy = clearing;
    end

    // Effective write/set strobes: suppressed while clearing and for the zero register.
    always_comb begin
        we0   = wen0 && !clearing && !is_zero_reg(waddr0);
        we1   = wen1 && !clearing && !is_zero_reg(waddr1);
        sb_en = set_busy && !clearing && !is_zero_reg(busy_addr);
    end

    always_comb begin
        mem_d         = mem_q;
        busy_d        = busy_q;
        wr_conflict_d = we0 && we1 && (waddr0 == waddr1);
        if (clearing) begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (we0) begin
                mem_d[waddr0]  = wdata0;
                busy_d[waddr0] = 1'b0;
            end
            if (we1) begin
                mem_d[waddr1]  = wdata1;
                busy_d[waddr1] = 1'b0;
            end
            if (sb_en)
                busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RFDEPTH; i++)
                mem_q[i] <= '0;
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    always_comb begin
        rdata1      = read_sel(raddr1, mem_q[raddr1], we0, waddr0, wdata0, we1, waddr1, wdata1);
        rdata2      = read_sel(raddr2, mem_q[raddr2], we0, waddr0, wdata0, we1, waddr1, wdata1);
        rbusy1      = busy_q[raddr1];
        rbusy2      = busy_q[raddr2];
        wr_conflict = wr_conflict_q;
    end

endmodule
